// File: rtl/alu_issue_seq.sv
// Single-issue sequencer: owns the 32x32 GPR file, steers operands into a combinational MIPS ALU,
// then retires via writeback, branch resolution or a lw/sw memory access. Optional overflow trap: ALU_ISSUE_OVF_TRAP_EN.
module alu_issue_seq #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic [31:0] alu_instruction,
    output logic [31:0] alu_regA,
    output logic [31:0] alu_regB,
    input  logic [31:0] alu_result,
    input  logic [2:0]  alu_flags,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        branch_taken,
    output logic        ovf_exc,
    output logic        mem_err,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

`ifdef ALU_ISSUE_OVF_TRAP_EN
    localparam bit OVF_TRAP = 1'b1;
`else
    localparam bit OVF_TRAP = 1'b0;
`endif

    localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ  = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LW    = 6'h23, OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_ADD  = 6'h20, FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {IDLE, EXEC, WB, MEM} state_t;

    state_t      state, state_nx;
    logic [31:0] ir, op_a, op_b, res_q, wdata_q;
    logic [2:0]  flags_q;
    logic [15:0] mem_cnt;
    logic        mem_err_q;

    logic [31:0] gpr [32];
    logic [31:0] gpr_vld;

    logic [4:0]  in_rs, in_rt, ir_rt, ir_rd;
    logic [31:0] in_rs_val, in_rt_val, ir_rt_val;
    logic        wb_en, wb_lt, wb_to_rt, can_trap, is_beq, is_bne, is_lw, is_sw, trap;
    logic        rf_we;
    logic [4:0]  rf_idx;
    logic [31:0] rf_wdata;

    assign in_rs = in_instr[25:21];
    assign in_rt = in_instr[20:16];
    assign ir_rt = ir[20:16];
    assign ir_rd = ir[15:11];

    // NOTE: the array itself has no reset; clearing the per-register valid bits makes every
    // register read as zero after reset without a 32-entry reset fan-out on the storage.
    assign in_rs_val = gpr_vld[in_rs]    ? gpr[in_rs]    : '0;
    assign in_rt_val = gpr_vld[in_rt]    ? gpr[in_rt]    : '0;
    assign ir_rt_val = gpr_vld[ir_rt]    ? gpr[ir_rt]    : '0;
    assign dbg_data  = gpr_vld[dbg_addr] ? gpr[dbg_addr] : '0;

    // Instruction class of the latched instruction.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        wb_en    = 1'b0;
        wb_lt    = 1'b0;
        wb_to_rt = 1'b0;
        can_trap = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        case (ir[31:26])
            OP_RTYPE: begin
                case (ir[5:0])
                    FN_ADD, FN_SUB: begin wb_en = 1'b1; can_trap = 1'b1; end
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLL, FN_SLLV, FN_SRL, FN_SRLV, FN_SRA, FN_SRAV: wb_en = 1'b1;
                    FN_SLT, FN_SLTU: begin wb_en = 1'b1; wb_lt = 1'b1; end
                    default: ;
                endcase
            end
            OP_ADDI:                            begin wb_en = 1'b1; wb_to_rt = 1'b1; can_trap = 1'b1; end
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin wb_en = 1'b1; wb_to_rt = 1'b1; end
            OP_SLTI, OP_SLTIU:                  begin wb_en = 1'b1; wb_to_rt = 1'b1; wb_lt = 1'b1; end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_LW:   is_lw  = 1'b1;
            OP_SW:   is_sw  = 1'b1;
            default: ;
        endcase
    end

    assign trap = OVF_TRAP & can_trap & flags_q[0];

    // Single regfile write port shared by load return and writeback; R0 is never written.
    always_comb begin
        rf_we    = 1'b0;
        rf_idx   = ir_rt;
        rf_wdata = mem_rdata;
        if (state == MEM && mem_ack && is_lw) begin
            rf_we = 1'b1;
        end else if (state == WB && wb_en && !trap) begin
            rf_we    = 1'b1;
            rf_idx   = wb_to_rt ? ir_rt : ir_rd;
            rf_wdata = wb_lt ? {31'b0, flags_q[1]} : res_q;
        end
        if (rf_idx == 5'd0) rf_we = 1'b0;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        done     = 1'b0;
        mem_req  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = EXEC;
            end
            EXEC: state_nx = (is_lw || is_sw) ? MEM : WB;
            MEM: begin
                mem_req = 1'b1;
                if (mem_ack || mem_cnt == TIMEOUT_CNT) state_nx = WB;
            end
            WB: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            ir        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            wdata_q   <= '0;
            mem_cnt   <= '0;
            mem_err_q <= 1'b0;
            gpr_vld   <= '0;
        end else begin
            state <= state_nx;
            if (rf_we) gpr_vld[rf_idx] <= 1'b1;
            case (state)
                IDLE: if (in_valid) begin
                    ir        <= in_instr;
                    mem_err_q <= 1'b0;
                    // The ALU expects rt in regA / rs in regB, or zero / rt when rs is $0.
                    if (in_rs != 5'd0) begin
                        op_a <= in_rt_val;
                        op_b <= in_rs_val;
                    end else begin
                        op_a <= '0;
                        op_b <= in_rt_val;
                    end
                end
                EXEC: begin
                    res_q   <= alu_result;
                    flags_q <= alu_flags;
                    wdata_q <= ir_rt_val;
                    mem_cnt <= 16'd1;
                end
                MEM: if (!mem_ack) begin
                    if (mem_cnt == TIMEOUT_CNT) mem_err_q <= 1'b1;
                    else                        mem_cnt   <= mem_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we && !rst) gpr[rf_idx] <= rf_wdata;
    end

    assign alu_instruction = ir;
    assign alu_regA        = op_a;
    assign alu_regB        = op_b;
    assign mem_we          = (state == MEM) & is_sw;
    assign mem_addr        = res_q;
    assign mem_wdata       = wdata_q;
    assign branch_taken    = done & ((is_beq & flags_q[2]) | (is_bne & ~flags_q[2]));
    assign ovf_exc         = done & trap;
    assign mem_err         = done & mem_err_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: MIPS ALU stub, architectural register model, directed cases and random instruction stream.
module tb_alu_issue_seq;
    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, mem_req, mem_we, mem_ack, done;
    logic        branch_taken, ovf_exc, mem_err;
    logic [31:0] in_instr, alu_instruction, alu_regA, alu_regB, alu_result;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_data;
    logic [2:0]  alu_flags;
    logic [4:0]  dbg_addr;

    alu_issue_seq #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .alu_instruction(alu_instruction), .alu_regA(alu_regA), .alu_regB(alu_regB),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .done(done), .branch_taken(branch_taken), .ovf_exc(ovf_exc), .mem_err(mem_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef enum {K_NONE, K_RD_RES, K_RD_LT, K_RT_RES, K_RT_LT, K_BEQ, K_BNE, K_LW, K_SW} kind_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mref [32];
    logic [31:0] cap_rega, cap_regb, cap_addr, rv;
    logic        cap_bt, cap_ovf, cap_merr;
    int          cap_req;

    // MIPS semantics on true source values s=R[rs], t=R[rt].
    function automatic void mips_eval(input logic [31:0] ins, input logic [31:0] s, input logic [31:0] t,
                                      output logic [31:0] r, output logic lt, output logic ov);
        logic [5:0]  op = ins[31:26];
        logic [5:0]  fn = ins[5:0];
        logic [4:0]  sh = ins[10:6];
        logic [31:0] se = {{16{ins[15]}}, ins[15:0]};
        logic [31:0] ze = {16'h0, ins[15:0]};
        r  = s ^ t;
        lt = $signed(s) < $signed(t);
        ov = 1'b0;
        case (op)
            6'h00: case (fn)
                6'h20, 6'h21: begin r = s + t; ov = (s[31] == t[31]) && (r[31] != s[31]); end
                6'h22, 6'h23: begin r = s - t; ov = (s[31] != t[31]) && (r[31] != s[31]); end
                6'h24: r = s & t;
                6'h25: r = s | t;
                6'h26: r = s ^ t;
                6'h27: r = ~(s | t);
                6'h00: r = t << sh;
                6'h02: r = t >> sh;
                6'h03: r = 32'($signed(t) >>> sh);
                6'h04: r = t << s[4:0];
                6'h06: r = t >> s[4:0];
                6'h07: r = 32'($signed(t) >>> s[4:0]);
                6'h2A: r = s - t;
                6'h2B: begin r = s - t; lt = s < t; end
                default: ;
            endcase
            6'h08, 6'h09: begin r = s + se; ov = (s[31] == se[31]) && (r[31] != s[31]); end
            6'h0A: begin r = s - se; lt = $signed(s) < $signed(se); end
            6'h0B: begin r = s - se; lt = s < se; end
            6'h0C: r = s & ze;
            6'h0D: r = s | ze;
            6'h0E: r = s ^ ze;
            6'h04, 6'h05: r = s - t;
            6'h23, 6'h2B: r = s + se;
            default: ;
        endcase
    endfunction

    function automatic kind_t classify(input logic [31:0] ins, output bit trapk);
        trapk = 1'b0;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20, 6'h22: begin trapk = 1'b1; return K_RD_RES; end
                6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: return K_RD_RES;
                6'h2A, 6'h2B: return K_RD_LT;
                default: return K_NONE;
            endcase
            6'h08: begin trapk = 1'b1; return K_RT_RES; end
            6'h09, 6'h0C, 6'h0D, 6'h0E: return K_RT_RES;
            6'h0A, 6'h0B: return K_RT_LT;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            default: return K_NONE;
        endcase
    endfunction

    // ALU stub: undo the sequencer's operand steering, then apply MIPS semantics.
    logic [31:0] alu_s, alu_t, alu_r;
    logic        alu_lt, alu_ov;
    always_comb begin
        if (alu_instruction[25:21] != 5'd0) begin
            alu_s = alu_regB;
            alu_t = alu_regA;
        end else begin
            alu_s = alu_regA;
            alu_t = alu_regB;
        end
        mips_eval(alu_instruction, alu_s, alu_t, alu_r, alu_lt, alu_ov);
    end
    assign alu_result = alu_r;
    assign alu_flags  = {alu_r == 32'd0, alu_lt, alu_ov};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic read_reg(input int idx, output logic [31:0] v);
        dbg_addr = 5'(idx);
        #1;
        v = dbg_data;
    endtask

    task automatic sweep(input int n);
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            read_reg(i, v);
            check($sformatf("gpr%0d", i), v, mref[i]);
        end
    endtask

    // Issue one instruction and check every cycle until it retires; ack_at is the MEM cycle carrying mem_ack.
    task automatic run_instr(input logic [31:0] ins, input int ack_at, input logic [31:0] rdata);
        logic [4:0]  rs = ins[25:21], rt = ins[20:16], rd = ins[15:11];
        logic [31:0] rsv = mref[rs], rtv = mref[rt], r;
        logic        lt, ov, exp_trap, exp_bt, acked, merr;
        bit          trapk;
        kind_t       kind;
        mips_eval(ins, rsv, rtv, r, lt, ov);
        kind     = classify(ins, trapk);
        exp_trap = 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
        exp_trap = trapk && ov;
`endif
        exp_bt = (kind == K_BEQ && rsv == rtv) || (kind == K_BNE && rsv != rtv);
        acked  = 1'b0;
        merr   = 1'b0;
        cap_req = 0;

        @(negedge clk);
        check("idle_ready", in_ready, 1);
        check("idle_done", done, 0);
        in_valid = 1'b1;
        in_instr = ins;
        @(negedge clk);
        in_valid = 1'b0;
        in_instr = $urandom;
        check("exec_ready", in_ready, 0);
        check("exec_done", done, 0);
        check("exec_instr", alu_instruction, ins);
        check("exec_regA", alu_regA, (rs != 0) ? rtv : 32'd0);
        check("exec_regB", alu_regB, (rs != 0) ? rsv : rtv);
        cap_rega = alu_regA;
        cap_regb = alu_regB;

        if (kind == K_LW || kind == K_SW) begin
            for (int c = 1; c <= int'(TMO); c++) begin
                @(negedge clk);
                check("mem_req", mem_req, 1);
                check("mem_done", done, 0);
                check("mem_we", mem_we, kind == K_SW);
                check("mem_addr", mem_addr, r);
                check("mem_wdata", mem_wdata, rtv);
                if (c == 1) cap_addr = mem_addr;
                if (mem_req) cap_req++;
                if (c == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                    acked     = 1'b1;
                    break;
                end
            end
            merr = !acked;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            check("wb_mem_req", mem_req, 0);
        end else begin
            @(negedge clk);
        end

        check("wb_done", done, 1);
        check("wb_branch", branch_taken, exp_bt);
        check("wb_ovf", ovf_exc, exp_trap);
        check("wb_mem_err", mem_err, merr);
        cap_bt   = branch_taken;
        cap_ovf  = ovf_exc;
        cap_merr = mem_err;

        case (kind)
            K_RD_RES: if (!exp_trap && rd != 0) mref[rd] = r;
            K_RD_LT:  if (rd != 0) mref[rd] = {31'b0, lt};
            K_RT_RES: if (!exp_trap && rt != 0) mref[rt] = r;
            K_RT_LT:  if (rt != 0) mref[rt] = {31'b0, lt};
            K_LW:     if (acked && rt != 0) mref[rt] = rdata;
            default: ;
        endcase

        @(negedge clk);
        check("post_done", done, 0);
        check("post_ready", in_ready, 1);
        sweep(8);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [5:0] fn_tab [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00,
                                    6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h2A, 6'h2B, 6'h3F};
        logic [5:0] op_tab [12] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                                    6'h04, 6'h05, 6'h23, 6'h2B, 6'h3F};
        int         k  = int'($urandom_range(0, 28));
        logic [4:0] rs = 5'($urandom_range(0, 7));
        logic [4:0] rt = 5'($urandom_range(0, 7));
        logic [4:0] rd = 5'($urandom_range(0, 7));
        logic [4:0] sh = 5'($urandom_range(0, 31));
        logic [15:0] imm = 16'($urandom);
        if (k < 17) return r_ins(fn_tab[k], rs, rt, rd, sh);
        return i_ins(op_tab[k-17], rs, rt, imm);
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; mem_ack = 1'b0; mem_rdata = '0; dbg_addr = '0;
        for (int i = 0; i < 32; i++) mref[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_done", done, 0);
        check("rst_branch", branch_taken, 0);
        check("rst_ovf", ovf_exc, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_alu_instr", alu_instruction, 0);
        check("rst_regA", alu_regA, 0);
        check("rst_regB", alu_regB, 0);
        rst = 1'b0;
        sweep(32);

        run_instr(i_ins(6'h08, 0, 1, 16'd5), 0, 0);
        run_instr(i_ins(6'h08, 0, 2, 16'd7), 0, 0);
        run_instr(r_ins(6'h20, 1, 2, 3, 0), 0, 0);
        check("add_regA_lit", cap_rega, 32'd7);
        check("add_regB_lit", cap_regb, 32'd5);
        read_reg(3, rv);
        check("add_r3_lit", rv, 32'd12);

        run_instr(i_ins(6'h08, 0, 1, 16'h7FFF), 0, 0);
        run_instr(r_ins(6'h00, 0, 1, 1, 16), 0, 0);
        run_instr(i_ins(6'h0D, 1, 1, 16'hFFFF), 0, 0);
        read_reg(1, rv);
        check("r1_max_lit", rv, 32'h7FFF_FFFF);
        run_instr(r_ins(6'h20, 1, 1, 6, 0), 0, 0);
        read_reg(6, rv);
`ifdef ALU_ISSUE_OVF_TRAP_EN
        check("ovf_trap_lit", cap_ovf, 1);
        check("ovf_r6_lit", rv, 32'd0);
`else
        check("ovf_trap_lit", cap_ovf, 0);
        check("ovf_r6_lit", rv, 32'hFFFF_FFFE);
`endif
        run_instr(r_ins(6'h21, 1, 1, 7, 0), 0, 0);
        read_reg(7, rv);
        check("addu_no_trap_lit", cap_ovf, 0);
        check("addu_r7_lit", rv, 32'hFFFF_FFFE);

        run_instr(i_ins(6'h04, 1, 1, 16'h0010), 0, 0);
        check("beq_taken_lit", cap_bt, 1);
        run_instr(i_ins(6'h05, 1, 1, 16'h0010), 0, 0);
        check("bne_taken_lit", cap_bt, 0);

        run_instr(i_ins(6'h08, 0, 1, 16'h0100), 0, 0);
        run_instr(i_ins(6'h23, 1, 4, 16'd8), 3, 32'hDEAD_BEEF);
        check("lw_addr_lit", cap_addr, 32'h108);
        read_reg(4, rv);
        check("lw_r4_lit", rv, 32'hDEAD_BEEF);
        run_instr(r_ins(6'h2A, 0, 1, 5, 0), 0, 0);
        read_reg(5, rv);
        check("slt_r5_lit", rv, 32'd1);

        run_instr(i_ins(6'h2B, 1, 4, 16'd0), 99, 0);
        check("sw_tmo_err_lit", cap_merr, 1);
        check("sw_tmo_req_cycles_lit", cap_req, TMO);

        repeat (200) begin
            int ack_at = ($urandom_range(0, 4) == 0) ? 99 : int'($urandom_range(1, TMO - 1));
            run_instr(gen_instr(), ack_at, $urandom);
        end

        // Reset in the middle of a memory access.
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = i_ins(6'h2B, 1, 2, 16'd4);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("rmem_req_before", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rmem_req_after", mem_req, 0);
        check("rmem_ready", in_ready, 1);
        check("rmem_done", done, 0);
        check("rmem_regA", alu_regA, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_ready", in_ready, 1);
        check("late_ack_done", done, 0);
        check("late_ack_req", mem_req, 0);
        for (int i = 0; i < 32; i++) mref[i] = '0;
        sweep(32);
        run_instr(i_ins(6'h08, 0, 1, 16'd3), 0, 0);
        read_reg(1, rv);
        check("post_rst_r1_lit", rv, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
